diad_trace_buf: RTL

//  Synthesizable multi-channel pipeline trace capture for the diad core.

---
 rtl/diad_trace_buf.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/diad_trace_buf.sv
// Multi-channel pipeline trace capture: circular sample buffer with arm/trigger/post-count
// freeze and an oldest-first valid/last readout stream.
module diad_trace_buf #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 7,
  parameter int DEPTH    = 64,
  localparam int AW      = $clog2(DEPTH),
  localparam int DW      = CHANNELS * WIDTH
) (
  input  logic          iw_clk,
  input  logic          iw_rst,
  input  logic          iw_en,
  input  logic [DW-1:0] iw_data,
  input  logic          iw_arm,
  input  logic          iw_trig,
  input  logic          iw_mode,
  input  logic [AW:0]   iw_post_cnt,
  input  logic          iw_rd_req,
  output logic          ow_rd_valid,
  output logic [DW-1:0] ow_rd_data,
  output logic          ow_rd_last,
  output logic [2:0]    ow_state,
  output logic [AW:0]   ow_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_DONE  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   post_q, post_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   rd_left_q, rd_left_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic [DW-1:0] rd_data_q;

  logic [DW-1:0] mem [DEPTH];

  logic          wr_en;
  logic          rd_en;
  logic          rd_zero;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   cnt_inc;
  logic [AW:0]   post_clamp;
  logic [AW-1:0] oldest;

  assign cnt_inc    = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
  assign post_clamp = (iw_post_cnt > DEPTH_C) ? DEPTH_C : iw_post_cnt;
  // A full buffer has count low bits of zero, so oldest falls on wr_ptr itself.
  assign oldest     = wr_ptr_q - count_q[AW-1:0];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    rd_ptr_d   = rd_ptr_q;
    rd_left_d  = rd_left_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_zero    = 1'b0;
    rd_addr    = rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (iw_arm) begin
          state_d  = S_ARMED;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end
      S_ARMED: begin
        if (iw_en) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = cnt_inc;
          if (iw_mode && cnt_inc == DEPTH_C) state_d = S_DONE;
        end
        if (!iw_mode && iw_trig) begin
          post_d  = post_clamp;
          state_d = (post_clamp == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (iw_en) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = cnt_inc;
          post_d   = post_q - 1'b1;
          if (post_q == {{AW{1'b0}}, 1'b1}) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (iw_rd_req) begin
          state_d    = S_READ;
          rd_en      = 1'b1;
          rd_valid_d = 1'b1;
          if (count_q == '0) begin
            rd_zero   = 1'b1;
            rd_last_d = 1'b1;
            rd_left_d = '0;
          end else begin
            rd_addr   = oldest;
            rd_ptr_d  = oldest + 1'b1;
            rd_left_d = count_q - 1'b1;
            rd_last_d = (count_q == {{AW{1'b0}}, 1'b1});
          end
        end
      end
      S_READ: begin
        if (rd_last_q) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (iw_rd_req && rd_left_q != '0) begin
          rd_en      = 1'b1;
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          rd_left_d  = rd_left_q - 1'b1;
          rd_last_d  = (rd_left_q == {{AW{1'b0}}, 1'b1});
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      rd_ptr_q   <= '0;
      rd_left_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_left_q  <= rd_left_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      if (rd_en) rd_data_q <= rd_zero ? '0 : mem[rd_addr];
    end
  end

  always_ff @(posedge iw_clk) begin
    if (wr_en && !iw_rst) mem[wr_ptr_q] <= iw_data;
  end

  assign ow_rd_valid = rd_valid_q;
  assign ow_rd_data  = rd_data_q;
  assign ow_rd_last  = rd_last_q;
  assign ow_state    = state_q;
  assign ow_count    = count_q;

endmodule
